store_write_buffer: RTL

Buffers 64-bit row stores from the store controller and drains them to the 16-bit data memory one word per accepted cycle. It sits directly downstream of the store controller/register block. It consumes that block's write strobe, 16-bit base address and 64-bit packed data from the four cores. It decouples the store controller from the single-word memory port and reports overflow.

---
 rtl/store_write_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// store_write_buffer: FIFO of 64-bit row stores drained one 16-bit lane per accepted cycle; 1-cycle push-to-memWE latency.
// memReady=0 holds the presented word; pushes while full are dropped and flagged sticky; STWB_COALESCE_EN enables same-address merging.
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memWrtoReg,
    input  logic [15:0] memAddr,
    input  logic [63:0] datatoMem,
    input  logic        memReady,
    output logic        memWE,
    output logic [15:0] memWAddr,
    output logic [15:0] memWData,
    output logic        bufFull,
    output logic        bufEmpty,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [1:0]    lane;
    logic          overflow_q;

    entry_t head_entry;
    logic   accept;
    logic   pop;
    logic   push;
    logic   drop;
    logic   coalesce;

    assign head_entry = mem[head];
    assign bufFull    = (count == FULL_CNT);
    assign bufEmpty   = (count == '0);
    assign overflow   = overflow_q;
    assign accept     = !bufEmpty && memReady;
    assign pop        = accept && (lane == 2'd3);

`ifdef STWB_COALESCE_EN
    // The newest entry may be merged only while its drain has not begun.
    logic [AW-1:0] last_idx;
    assign last_idx = tail - PTR_ONE;
    assign coalesce = memWrtoReg && !bufEmpty
                      && (mem[last_idx].addr == memAddr)
                      && !((last_idx == head) && (lane != 2'd0));
`else
    assign coalesce = 1'b0;
`endif

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign push = memWrtoReg && !bufFull && !coalesce;
    assign drop = memWrtoReg && bufFull && !coalesce;

    always_comb begin
        memWE    = 1'b0;
        memWAddr = '0;
        memWData = '0;
        if (!bufEmpty) begin
            memWE    = 1'b1;
            memWAddr = head_entry.addr + {14'd0, lane};
            memWData = head_entry.data[lane*16 +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            lane       <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) lane <= lane + 2'd1;
            if (pop)    head <= head + PTR_ONE;
            if (push)   tail <= tail + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push) begin
                mem[tail] <= {memAddr, datatoMem};
            end
`ifdef STWB_COALESCE_EN
            else if (coalesce) begin
                mem[last_idx].data <= datatoMem;
            end
`endif
        end
    end
endmodule
